// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Recovers 8N1 / 8E1 / 8O1 frames from an
//               asynchronous serial line oversampled PRESCALE clocks per bit.
//               Each bit is decided by a 2-of-3 majority around mid-bit.
//               A good frame updates o_p_data together with a one-cycle
//               o_data_valid pulse. A bad frame gives a one-cycle o_par_err
//               and/or o_stp_err pulse and leaves o_p_data unchanged.
// Ports       : clk          - clock, rising edge
//               reset        - synchronous, active-high
//               i_rx_in      - asynchronous serial line (idles high)
//               i_prescale   - clocks per bit (even, 4..32; otherwise 8)
//               i_par_en     - parity bit present
//               i_par_typ    - 0: parity = ~^data, 1: parity = ^data
//               o_p_data     - last good byte
//               o_data_valid - good-frame pulse
//               o_par_err    - parity-mismatch pulse
//               o_stp_err    - stop-bit-low pulse
//               o_rx_busy    - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_rx_in,
    input  logic [PRESC_W-1:0] i_prescale,
    input  logic               i_par_en,
    input  logic               i_par_typ,
    output logic [DATA_W-1:0]  o_p_data,
    output logic               o_data_valid,
    output logic               o_par_err,
    output logic               o_stp_err,
    output logic               o_rx_busy
);

    localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [PRESC_W-1:0]   c_ONE           = PRESC_W'(1);
    localparam logic [PRESC_W-1:0]   c_DEFAULT_PRESC = PRESC_W'(8);
    localparam logic [PRESC_W-1:0]   c_MIN_PRESC     = PRESC_W'(4);
    localparam logic [PRESC_W-1:0]   c_MAX_PRESC     = PRESC_W'(32);
    localparam logic [BIT_CNT_W-1:0] c_LAST_BIT      = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] c_BIT_ONE       = BIT_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Synchroniser and per-frame latched configuration
    logic                 r_sync1;
    logic                 r_sync2;
    logic [PRESC_W-1:0]   r_presc;
    logic                 r_par_en;
    logic                 r_par_typ;

    // Bit timing and assembly
    logic [PRESC_W-1:0]   r_edge_cnt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]    r_shift;
    logic                 r_samp_lo;
    logic                 r_samp_mid;
    logic                 r_par_bad;

    logic                 w_rx_s;
    logic                 w_start;
    logic                 w_presc_ok;
    logic [PRESC_W-1:0]   w_half;
    logic [PRESC_W-1:0]   w_samp_lo_pt;
    logic [PRESC_W-1:0]   w_samp_hi_pt;
    logic [PRESC_W-1:0]   w_bit_last;
    logic                 w_at_lo;
    logic                 w_at_mid;
    logic                 w_resolve;
    logic                 w_bit_end;
    logic                 w_majority;
    logic                 w_exp_par;
    logic                 w_last_bit;

    assign w_rx_s  = r_sync2;
    assign w_start = (r_state == S_IDLE) && !w_rx_s;

    assign w_presc_ok = !i_prescale[0]
                        && (i_prescale >= c_MIN_PRESC)
                        && (i_prescale <= c_MAX_PRESC);

    assign w_half       = r_presc >> 1;
    assign w_samp_lo_pt = w_half - c_ONE;
    assign w_samp_hi_pt = w_half + c_ONE;
    assign w_bit_last   = r_presc - c_ONE;

    assign w_at_lo   = (r_edge_cnt == w_samp_lo_pt);
    assign w_at_mid  = (r_edge_cnt == w_half);
    assign w_resolve = (r_edge_cnt == w_samp_hi_pt);
    assign w_bit_end = (r_edge_cnt == w_bit_last);

    // Third sample is the live synchronised line on the resolve cycle
    assign w_majority = (r_samp_lo & r_samp_mid)
                      | (r_samp_lo & w_rx_s)
                      | (r_samp_mid & w_rx_s);

    assign w_exp_par  = r_par_typ ? (^r_shift) : (~^r_shift);
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    assign o_rx_busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle (high) line level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A start bit that reads high at mid-bit was a glitch
                if (w_resolve && w_majority) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && w_last_bit) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Leave early so the tail of the stop bit is spent in IDLE
                // and a back-to-back start edge is not missed.
                if (w_resolve) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: configuration latch, edge/bit counters, sampling, shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= c_DEFAULT_PRESC;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_samp_lo  <= 1'b1;
            r_samp_mid <= 1'b1;
            r_par_bad  <= 1'b0;
        end else begin
            if (w_start) begin
                r_presc   <= w_presc_ok ? i_prescale : c_DEFAULT_PRESC;
                r_par_en  <= i_par_en;
                r_par_typ <= i_par_typ;
                r_par_bad <= 1'b0;
                r_bit_cnt <= '0;
            end

            // The start-detect cycle is edge 0, so the first START cycle is edge 1
            if (r_state == S_IDLE) begin
                r_edge_cnt <= w_start ? c_ONE : '0;
            end else if (w_bit_end || (w_state_nxt == S_IDLE)) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + c_ONE;
            end

            if (r_state != S_IDLE) begin
                if (w_at_lo) begin
                    r_samp_lo <= w_rx_s;
                end
                if (w_at_mid) begin
                    r_samp_mid <= w_rx_s;
                end
            end

            if (r_state == S_DATA) begin
                if (w_resolve) begin
                    r_shift <= {w_majority, r_shift[DATA_W-1:1]};
                end
                if (w_bit_end) begin
                    r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                end
            end

            if ((r_state == S_PARITY) && w_resolve) begin
                r_par_bad <= (w_majority != w_exp_par);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered frame result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            o_p_data     <= '0;
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stp_err    <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stp_err    <= 1'b0;
            if ((r_state == S_STOP) && w_resolve) begin
                o_stp_err <= !w_majority;
                o_par_err <= r_par_bad;
                if (w_majority && !r_par_bad) begin
                    o_data_valid <= 1'b1;
                    o_p_data     <= r_shift;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A directed table of frames,
//               hand-written corner sequences (glitch, back-to-back, reset
//               mid-frame) and randomized frames scored against a frame-level
//               reference model of result timing, flags and held data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_rx_in = 1'b1;
    logic [5:0] i_prescale = 6'd8;
    logic       i_par_en = 1'b0;
    logic       i_par_typ = 1'b0;
    logic [7:0] o_p_data;
    logic       o_data_valid;
    logic       o_par_err;
    logic       o_stp_err;
    logic       o_rx_busy;

    uart_rx #(
        .DATA_W  (8),
        .PRESC_W (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_in      (i_rx_in),
        .i_prescale   (i_prescale),
        .i_par_en     (i_par_en),
        .i_par_typ    (i_par_typ),
        .o_p_data     (o_p_data),
        .o_data_valid (o_data_valid),
        .o_par_err    (o_par_err),
        .o_stp_err    (o_stp_err),
        .o_rx_busy    (o_rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pd;
    } ev_t;

    ev_t act_q[$];
    ev_t exp_q[$];

    int         n_vec = 0;
    int         n_err = 0;
    int         last_exp = 0;
    logic [7:0] last_good = 8'h00;

    // Record every result pulse seen on the outputs
    always @(negedge clk) begin
        if (!reset && (o_data_valid || o_par_err || o_stp_err)) begin
            ev_t a;
            a.cyc = cyc;
            a.dv  = o_data_valid;
            a.pe  = o_par_err;
            a.se  = o_stp_err;
            a.pd  = o_p_data;
            act_q.push_back(a);
        end
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Drivers run at posedge+1; checks run at negedge
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input bit dv, input bit pe, input bit se, input logic [7:0] pd);
        ev_t e;
        e.cyc = c;
        e.dv  = dv;
        e.pe  = pe;
        e.se  = se;
        e.pd  = pd;
        exp_q.push_back(e);
        if (c > last_exp) last_exp = c;
    endtask

    // Frame-level reference: parity from a ones count, latency from bit
    // count (start + data [+ parity]) plus half of the stop bit and the
    // synchroniser/result-register delays.
    task automatic model_push(input int c_start, input logic [7:0] d, input int p,
                              input bit pen, input bit ptyp, input bit pbit, input bit sbit);
        int         ones;
        int         nbits;
        bit         want_par;
        bit         par_ok;
        bit         good;
        logic [7:0] pd;
        ones     = $countones(d);
        want_par = ptyp ? (ones % 2 == 1) : (ones % 2 == 0);
        par_ok   = !pen || (pbit == want_par);
        good     = par_ok && sbit;
        nbits    = pen ? 10 : 9;
        if (good) last_good = d;
        pd = last_good;
        push_exp(c_start + 2 + nbits * p + p / 2 + 2, good, !par_ok, !sbit, pd);
    endtask

    // Drive one frame at bclk clocks per bit. Configuration ports are
    // scrambled during the data bits to show they are only taken at start.
    task automatic send_frame(input logic [7:0] d, input int bclk, input logic [5:0] port,
                              input bit pen, input bit ptyp, input bit pbit, input bit sbit,
                              output int c_start);
        i_prescale = port;
        i_par_en   = pen;
        i_par_typ  = ptyp;
        i_rx_in    = 1'b0;
        c_start    = cyc;
        hold(bclk);
        i_prescale = 6'($urandom);
        i_par_en   = 1'($urandom);
        i_par_typ  = 1'($urandom);
        for (int b = 0; b < 8; b++) begin
            i_rx_in = d[b];
            hold(bclk);
        end
        i_prescale = port;
        i_par_en   = pen;
        i_par_typ  = ptyp;
        if (pen) begin
            i_rx_in = pbit;
            hold(bclk);
        end
        i_rx_in = sbit;
        hold(bclk);
        i_rx_in = 1'b1;
    endtask

    task automatic drain_and_compare(input string tag);
        ev_t e;
        ev_t a;
        int  k;
        while (cyc < last_exp + 40) hold(1);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s[%0d] result: missing, expected at cycle %0d", tag, k, e.cyc);
            end else begin
                a = act_q.pop_front();
                chk($sformatf("%s[%0d] cycle", tag, k), a.cyc, e.cyc);
                chk($sformatf("%s[%0d] data_valid", tag, k), {31'd0, a.dv}, {31'd0, e.dv});
                chk($sformatf("%s[%0d] par_err", tag, k), {31'd0, a.pe}, {31'd0, e.pe});
                chk($sformatf("%s[%0d] stp_err", tag, k), {31'd0, a.se}, {31'd0, e.se});
                chk($sformatf("%s[%0d] p_data", tag, k), {24'd0, a.pd}, {24'd0, e.pd});
            end
            k++;
        end
        while (act_q.size() > 0) begin
            a = act_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s extra result at cycle %0d: dv=%0b pe=%0b se=%0b, expected none",
                     tag, a.cyc, a.dv, a.pe, a.se);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         bclk;
        logic [5:0] port;
        bit         pen;
        bit         ptyp;
        bit         pbit;
        bit         sbit;
        int         gap;
        bit         dv;
        bit         pe;
        bit         se;
        int         lat;
        logic [7:0] pd;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] data, input int bclk, input logic [5:0] port,
                                 input bit pen, input bit ptyp, input bit pbit, input bit sbit,
                                 input int gap, input bit dv, input bit pe, input bit se,
                                 input int lat, input logic [7:0] pd);
        vec_t v;
        v.data = data; v.bclk = bclk; v.port = port;
        v.pen = pen; v.ptyp = ptyp; v.pbit = pbit; v.sbit = sbit; v.gap = gap;
        v.dv = dv; v.pe = pe; v.se = se; v.lat = lat; v.pd = pd;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        int         cs;
        int         cs2;
        int         n;
        int         p;
        int         gap;
        logic [5:0] port;
        logic [7:0] d;
        bit         pen;
        bit         ptyp;
        bit         pbit;
        bit         sbit;

        //            data  bclk port pen typ pb sb gap  dv pe se  lat  p_data
        tbl[0]  = mkv(8'hA5,  8, 6'd8,  0, 0, 0, 1,  4,  1, 0, 0,  78, 8'hA5);
        tbl[1]  = mkv(8'h3C,  8, 6'd8,  1, 0, 1, 1,  4,  1, 0, 0,  86, 8'h3C);
        tbl[2]  = mkv(8'h3C,  8, 6'd8,  1, 0, 0, 1,  4,  0, 1, 0,  86, 8'h3C);
        tbl[3]  = mkv(8'h81, 16, 6'd16, 0, 0, 0, 0, 24,  0, 0, 1, 154, 8'h3C);
        tbl[4]  = mkv(8'h07,  8, 6'd8,  1, 1, 1, 1,  4,  1, 0, 0,  86, 8'h07);
        tbl[5]  = mkv(8'h07,  8, 6'd8,  1, 1, 0, 0, 16,  0, 1, 1,  86, 8'h07);
        tbl[6]  = mkv(8'h5A,  8, 6'd7,  0, 0, 0, 1,  4,  1, 0, 0,  78, 8'h5A);
        tbl[7]  = mkv(8'hC3,  4, 6'd4,  0, 0, 0, 1,  0,  1, 0, 0,  40, 8'hC3);
        tbl[8]  = mkv(8'h96, 32, 6'd32, 1, 0, 1, 1,  4,  1, 0, 0, 338, 8'h96);
        tbl[9]  = mkv(8'h2A,  8, 6'd2,  1, 1, 0, 1,  4,  0, 1, 0,  86, 8'h96);
        tbl[10] = mkv(8'hE4,  8, 6'd34, 0, 0, 0, 1,  4,  1, 0, 0,  78, 8'hE4);

        // Reset state
        reset = 1'b1;
        hold(4);
        at_neg(cyc);
        chk("reset p_data", {24'd0, o_p_data}, 32'd0);
        chk("reset data_valid", {31'd0, o_data_valid}, 32'd0);
        chk("reset par_err", {31'd0, o_par_err}, 32'd0);
        chk("reset stp_err", {31'd0, o_stp_err}, 32'd0);
        chk("reset rx_busy", {31'd0, o_rx_busy}, 32'd0);
        hold(1);
        reset = 1'b0;
        hold(5);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].data, tbl[i].bclk, tbl[i].port, tbl[i].pen, tbl[i].ptyp,
                       tbl[i].pbit, tbl[i].sbit, cs);
            push_exp(cs + 2 + tbl[i].lat, tbl[i].dv, tbl[i].pe, tbl[i].se, tbl[i].pd);
            if (tbl[i].dv) last_good = tbl[i].data;
            hold(tbl[i].gap);
        end
        drain_and_compare("table");

        // Two-cycle glitch: busy for start-bit edges 1..5 only, no result
        hold(1);
        i_prescale = 6'd8;
        i_par_en   = 1'b0;
        i_rx_in    = 1'b0;
        n          = cyc;
        hold(2);
        i_rx_in    = 1'b1;
        at_neg(n + 2);
        chk("glitch busy at detect", {31'd0, o_rx_busy}, 32'd0);
        at_neg(n + 3);
        chk("glitch busy edge1", {31'd0, o_rx_busy}, 32'd1);
        at_neg(n + 7);
        chk("glitch busy edge5", {31'd0, o_rx_busy}, 32'd1);
        at_neg(n + 8);
        chk("glitch busy after", {31'd0, o_rx_busy}, 32'd0);
        hold(10);
        send_frame(8'h55, 8, 6'd8, 0, 0, 0, 1, cs);
        model_push(cs, 8'h55, 8, 0, 0, 0, 1);
        hold(4);
        drain_and_compare("glitch");

        // Back-to-back frames, one stop bit each: results 80 cycles apart
        send_frame(8'h01, 8, 6'd8, 0, 0, 0, 1, cs);
        model_push(cs, 8'h01, 8, 0, 0, 0, 1);
        send_frame(8'hFE, 8, 6'd8, 0, 0, 0, 1, cs2);
        model_push(cs2, 8'hFE, 8, 0, 0, 0, 1);
        hold(4);
        drain_and_compare("b2b");

        // Reset during data bit 4
        d = 8'h0F;
        i_prescale = 6'd8;
        i_par_en   = 1'b0;
        i_rx_in    = 1'b0;
        hold(8);
        for (int b = 0; b < 4; b++) begin
            i_rx_in = d[b];
            hold(8);
        end
        i_rx_in = d[4];
        hold(4);
        reset   = 1'b1;
        i_rx_in = 1'b1;
        hold(1);
        reset   = 1'b0;
        at_neg(cyc);
        chk("midreset p_data", {24'd0, o_p_data}, 32'd0);
        chk("midreset data_valid", {31'd0, o_data_valid}, 32'd0);
        chk("midreset par_err", {31'd0, o_par_err}, 32'd0);
        chk("midreset stp_err", {31'd0, o_stp_err}, 32'd0);
        chk("midreset rx_busy", {31'd0, o_rx_busy}, 32'd0);
        last_good = 8'h00;
        hold(20);
        send_frame(8'h7E, 8, 6'd8, 0, 0, 0, 1, cs);
        model_push(cs, 8'h7E, 8, 0, 0, 0, 1);
        hold(4);
        drain_and_compare("midreset");

        // Randomized frames against the reference model
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0) port = 6'(2 * $urandom_range(2, 16));
            else                           port = 6'($urandom_range(0, 63));
            if (!port[0] && port >= 6'd4 && port <= 6'd32) p = int'(port);
            else                                            p = 8;
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            pbit = 1'($urandom);
            sbit = ($urandom_range(0, 4) != 0);
            gap  = sbit ? $urandom_range(0, 6) : 8 + $urandom_range(0, 6);
            send_frame(d, p, port, pen, ptyp, pbit, sbit, cs);
            model_push(cs, d, p, pen, ptyp, pbit, sbit);
            hold(gap);
        end
        drain_and_compare("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
